// File: rtl/indep_drv_pkg.sv
// Shared types, widths and the golden s1..s19 path tables for the indep controller driver.
// Entry i of each table is the value used on step i; unused tail entries are zero.
package indep_drv_pkg;
   localparam int X_W       = 6;
   localparam int Y_W       = 23;
   localparam int STEP_W    = 4;
   localparam int MAX_STEPS = 16;
   localparam logic [STEP_W-1:0] FAIL_NONE = 4'hF;

   typedef enum logic [1:0] {IDLE, RSTD, RUN, FIN} state_t;

   typedef logic [MAX_STEPS-1:0][X_W-1:0] xtab_t;
   typedef logic [MAX_STEPS-1:0][Y_W-1:0] ytab_t;

   // Concatenations list entry 15 first, entry 0 last.
   localparam xtab_t X = {{6{6'h00}},
                          6'h00, 6'h08, 6'h08, 6'h08, 6'h00,
                          6'h08, 6'h08, 6'h04, 6'h0C, 6'h08};

   localparam ytab_t Y = {{6{23'h000000}},
                          23'h400000, 23'h400000, 23'h000000, 23'h000000, 23'h000002,
                          23'h000004, 23'h202000, 23'h400000, 23'h008000, 23'h1E0040};

   localparam ytab_t M = {16{23'h7FFFFF}};
endpackage

// File: rtl/indep_path_rom.sv
// Combinational path lookup: step index -> stimulus word, golden response and compare mask.
module indep_path_rom
   import indep_drv_pkg::*;
#(
   parameter xtab_t X_TAB = X,
   parameter ytab_t Y_TAB = Y,
   parameter ytab_t M_TAB = M
) (
   input  logic [STEP_W-1:0] step,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [Y_W-1:0]    m
);
   assign x = X_TAB[step];
   assign y = Y_TAB[step];
   assign m = M_TAB[step];
endmodule

// File: rtl/indep_path_driver.sv
// Resets the indep controller, walks it along the golden path one step per cycle and
// reports pass or the first mismatching step together with the captured output word.
module indep_path_driver
   import indep_drv_pkg::*;
#(
   parameter int    NUM_STEPS  = 10,
   parameter int    RST_CYCLES = 2,
   parameter xtab_t X_TAB      = X,
   parameter ytab_t Y_TAB      = Y,
   parameter ytab_t M_TAB      = M
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              key_in,
   output logic              dut_rst,
   output logic [X_W-1:0]    x_out,
   output logic              key_out,
   input  logic [Y_W-1:0]    y_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [STEP_W-1:0] fail_step,
   output logic [Y_W-1:0]    y_capture
);
   localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
   localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);

   generate
      if (NUM_STEPS < 1 || NUM_STEPS > MAX_STEPS || RST_CYCLES < 1) begin : g_bad_param
         $error("indep_path_driver: NUM_STEPS must be 1..16 and RST_CYCLES >= 1");
      end
   endgenerate

   state_t            r_state;
   logic [STEP_W-1:0] r_step;
   logic [CNT_W-1:0]  r_rst_cnt;
   logic              r_dut_rst;
   logic [X_W-1:0]    r_x;
   logic              r_key;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic [STEP_W-1:0] r_fail_step;
   logic [Y_W-1:0]    r_y_cap;

   logic [STEP_W-1:0] w_step_nxt;
   logic [X_W-1:0]    w_x_cur;
   logic [X_W-1:0]    w_x_nxt;
   logic [Y_W-1:0]    w_y_cur;
   logic [Y_W-1:0]    w_m_cur;
   logic [Y_W-1:0]    w_y_unused;
   logic [Y_W-1:0]    w_m_unused;
   logic              w_mismatch;

   // Second lookup supplies the stimulus for the step about to be loaded (0 when leaving RSTD).
   assign w_step_nxt = (r_state == RUN) ? r_step + 4'd1 : '0;

   indep_path_rom #(.X_TAB(X_TAB), .Y_TAB(Y_TAB), .M_TAB(M_TAB)) u_rom_cur (
      .step (r_step),
      .x    (w_x_cur),
      .y    (w_y_cur),
      .m    (w_m_cur)
   );

   indep_path_rom #(.X_TAB(X_TAB), .Y_TAB(Y_TAB), .M_TAB(M_TAB)) u_rom_nxt (
      .step (w_step_nxt),
      .x    (w_x_nxt),
      .y    (w_y_unused),
      .m    (w_m_unused)
   );

   assign w_mismatch = |((y_in ^ w_y_cur) & w_m_cur);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_step      <= '0;
         r_rst_cnt   <= '0;
         r_dut_rst   <= 1'b1;
         r_x         <= '0;
         r_key       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_step <= FAIL_NONE;
         r_y_cap     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_dut_rst <= 1'b1;
               r_x       <= '0;
               if (start) begin
                  r_key       <= key_in;
                  r_pass      <= 1'b0;
                  r_fail_step <= FAIL_NONE;
                  r_y_cap     <= '0;
                  r_busy      <= 1'b1;
                  r_rst_cnt   <= '0;
                  r_state     <= RSTD;
               end
            end
            RSTD: begin
               if (r_rst_cnt == RST_LAST) begin
                  r_dut_rst <= 1'b0;
                  r_x       <= w_x_nxt;
                  r_step    <= '0;
                  r_state   <= RUN;
               end else begin
                  r_rst_cnt <= r_rst_cnt + 1'b1;
               end
            end
            RUN: begin
               if (w_mismatch) begin
                  r_fail_step <= r_step;
                  r_y_cap     <= y_in;
                  r_state     <= FIN;
               end else if (r_step == LAST_STEP) begin
                  r_pass  <= 1'b1;
                  r_state <= FIN;
               end else begin
                  r_step <= r_step + 1'b1;
                  r_x    <= w_x_nxt;
               end
            end
            FIN: begin
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_dut_rst <= 1'b1;
               r_x       <= '0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign dut_rst   = r_dut_rst;
   assign x_out     = r_x;
   assign key_out   = r_key;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail_step = r_fail_step;
   assign y_capture = r_y_cap;
endmodule

// File: tb/tb_indep_path_driver.sv
// Bench for indep_path_driver: a behavioural path controller answers on falling edges,
// run results are queued at start and compared when done pulses.
module tb_indep_path_driver;
   import indep_drv_pkg::*;

   localparam ytab_t M_ALT = {{15{23'h7FFFFF}}, 23'h000040};

   logic        clk = 1'b0;
   logic        rst, start, key_in;
   logic        dut_rst, key_out, busy, done, pass;
   logic [5:0]  x_out;
   logic [22:0] y_in;
   logic [3:0]  fail_step;
   logic [22:0] y_capture;
   logic        m_dut_rst, m_key_out, m_busy, m_done, m_pass;
   logic [5:0]  m_x_out;
   logic [3:0]  m_fail_step;
   logic [22:0] m_y_capture;

   logic [5:0]  x_tb [10] = '{6'h08, 6'h0C, 6'h04, 6'h08, 6'h08, 6'h00, 6'h08, 6'h08, 6'h08, 6'h00};
   logic [22:0] y_tb [10] = '{23'h1E0040, 23'h008000, 23'h400000, 23'h202000, 23'h000004,
                              23'h000002, 23'h000000, 23'h000000, 23'h400000, 23'h400000};

   typedef struct {
      logic        pass;
      logic [3:0]  fs;
      logic [22:0] cap;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int          n_chk  = 0;
   int          n_pass = 0;
   int          idx    = 0;
   int          c_step = -1;
   logic [22:0] c_xor  = '0;
   logic        exp_key = 1'b0;
   int          exp_last = 9;
   logic        use_m = 1'b0;

   always #5 clk = ~clk;

   indep_path_driver dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .dut_rst(dut_rst),
      .x_out(x_out), .key_out(key_out), .y_in(y_in), .busy(busy), .done(done),
      .pass(pass), .fail_step(fail_step), .y_capture(y_capture)
   );

   indep_path_driver #(.M_TAB(M_ALT)) dut_m (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .dut_rst(m_dut_rst),
      .x_out(m_x_out), .key_out(m_key_out), .y_in(y_in), .busy(m_busy), .done(m_done),
      .pass(m_pass), .fail_step(m_fail_step), .y_capture(m_y_capture)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Behavioural controller: steps through the golden path, outputs change on the falling edge.
   always @(negedge clk) begin
      logic       c_rst;
      logic [5:0] c_x;
      logic       c_k;
      c_rst = use_m ? m_dut_rst : dut_rst;
      c_x   = use_m ? m_x_out : x_out;
      c_k   = use_m ? m_key_out : key_out;
      if (c_rst) begin
         idx  = 0;
         y_in = '0;
      end else begin
         if (idx <= exp_last) begin
            chk($sformatf("x_out[%0d]", idx), c_x, x_tb[idx]);
            chk("key_out", c_k, exp_key);
         end
         y_in = (idx < 10) ? (y_tb[idx] ^ ((idx == c_step) ? c_xor : 23'h0)) : '0;
         idx++;
      end
   end

   task automatic run(input logic key, input int cstep, input logic [22:0] cxor,
                      input bit restart, input int rst_step, input bit chk_m);
      exp_t e;
      int   cyc, n_done, m_seen;
      bit   fails;
      fails    = (cstep >= 0 && cstep < 10 && cxor != 0);
      e.pass   = !fails;
      e.fs     = fails ? 4'(cstep) : 4'hF;
      e.cap    = fails ? (y_tb[cstep] ^ cxor) : 23'h0;
      e.cyc    = 2 + (fails ? cstep : 9) + 2;
      c_step   = cstep;
      c_xor    = cxor;
      exp_key  = key;
      use_m    = chk_m;
      exp_last = (fails && !chk_m) ? cstep : 9;
      if (rst_step < 0) sb.push_back(e);
      n_done = 0;
      m_seen = 0;
      start  = 1'b1;
      key_in = key;
      @(posedge clk); #1;
      start  = 1'b0;
      key_in = ~key;
      cyc    = 0;
      chk("busy_start", busy, 1'b1);
      while (cyc < 18) begin
         @(posedge clk); #1;
         cyc++;
         start = restart && (cyc == 5);
         if (cyc == 1) chk("dut_rst_hold", dut_rst, 1'b1);
         if (cyc == 2 && !(fails && cstep == 0)) chk("dut_rst_rel", dut_rst, 1'b0);
         if (rst_step >= 0 && cyc == 2 + rst_step) rst = 1'b1;
         if (rst_step >= 0 && cyc == 3 + rst_step) begin
            rst = 1'b0;
            chk("abort_busy", busy, 1'b0);
            chk("abort_dut_rst", dut_rst, 1'b1);
            chk("abort_x_out", x_out, 6'h00);
         end
         if (chk_m && m_done) begin
            m_seen++;
            chk("m_pass", m_pass, 1'b1);
            chk("m_fail_step", m_fail_step, 4'hF);
            chk("m_done_cyc", cyc, 13);
         end
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("sb_unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("pass", pass, e.pass);
               chk("fail_step", fail_step, e.fs);
               chk("y_capture", y_capture, e.cap);
               chk("done_cyc", cyc, e.cyc);
               chk("fin_dut_rst", dut_rst, 1'b1);
               chk("fin_x_out", x_out, 6'h00);
               chk("fin_busy", busy, 1'b0);
               $display("run key=%0d cstep=%0d: pass=%0d fail_step=%0h y_capture=%06h done@%0d",
                        key, cstep, pass, fail_step, y_capture, cyc);
            end
         end
      end
      start = 1'b0;
      chk("done_count", n_done, (rst_step < 0) ? 1 : 0);
      if (chk_m) chk("m_done_count", m_seen, 1);
      sb.delete();
      use_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      key_in = 1'b0;
      y_in   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dut_rst", dut_rst, 1'b1);
      chk("rst_x_out", x_out, 6'h00);
      chk("rst_key_out", key_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_fail_step", fail_step, 4'hF);
      chk("rst_y_capture", y_capture, 23'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      run(1'b1, -1, 23'h0,       1'b0, -1, 1'b0);   // clean pass, key 1
      run(1'b1,  4, 23'h000004,  1'b0, -1, 1'b0);   // y3 dropped on step 4
      run(1'b0, -1, 23'h0,       1'b0, -1, 1'b0);   // key 0 held throughout
      run(1'b1, -1, 23'h0,       1'b1, -1, 1'b0);   // start mid-run ignored
      run(1'b1, -1, 23'h0,       1'b0,  6, 1'b0);   // rst abort at step 6
      run(1'b1, -1, 23'h0,       1'b0, -1, 1'b0);   // recovery after abort
      run(1'b1,  0, 23'h020000,  1'b0, -1, 1'b1);   // y18 corrupt, masked in dut_m

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
